// File: rtl/vx_operand_gather.sv
// Operand-fetch stage: reads up to three source register vectors
// through a single GPR read port and hands the packet to dispatch.
module vx_operand_gather #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_BITS    = 2,
    parameter int META_W      = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [META_W-1:0]               in_meta,
    input  logic [WIS_BITS-1:0]             in_wis,
    input  logic [NR_BITS-1:0]              in_rs1,
    input  logic [NR_BITS-1:0]              in_rs2,
    input  logic [NR_BITS-1:0]              in_rs3,
    input  logic [2:0]                      in_rs_mask,
    output logic                            gpr_req_valid,
    output logic [WIS_BITS+NR_BITS-1:0]     gpr_req_addr,
    input  logic [NUM_THREADS*XLEN-1:0]     gpr_rsp_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [META_W-1:0]               out_meta,
    output logic [NUM_THREADS*XLEN-1:0]     out_rs1_data,
    output logic [NUM_THREADS*XLEN-1:0]     out_rs2_data,
    output logic [NUM_THREADS*XLEN-1:0]     out_rs3_data
);

    localparam int DW = NUM_THREADS * XLEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [WIS_BITS-1:0]   wis_q;
    logic [NR_BITS-1:0]    rs1_q, rs2_q, rs3_q;
    logic [2:0]            need_q;
    logic [2:0]            sent_q;
    logic [META_W-1:0]     meta_q;
    logic [DW-1:0]         d1_q, d2_q, d3_q;
    logic                  pend_q;
    logic [1:0]            pidx_q;

    logic                  accept;
    logic [2:0]            in_need;
    logic [2:0]            remain;
    logic                  req_v;
    logic [1:0]            req_idx;
    logic [2:0]            req_oh;
    logic [NR_BITS-1:0]    req_rs;

    // Register 0 reads as zero, so it never costs a read cycle.
    assign in_need = in_rs_mask & {in_rs3 != '0, in_rs2 != '0, in_rs1 != '0};
    assign accept  = in_valid && (state_q == IDLE);
    assign remain  = need_q & ~sent_q;

    always_comb begin
        state_d = state_q;
        req_v   = 1'b0;
        req_idx = 2'd0;
        req_oh  = 3'b000;
        req_rs  = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (in_need != 3'b000) ? REQ : OUT;
                end
            end
            REQ: begin
                req_v = 1'b1;
                if (remain[0]) begin
                    req_idx = 2'd0;
                    req_oh  = 3'b001;
                    req_rs  = rs1_q;
                end else if (remain[1]) begin
                    req_idx = 2'd1;
                    req_oh  = 3'b010;
                    req_rs  = rs2_q;
                end else begin
                    req_idx = 2'd2;
                    req_oh  = 3'b100;
                    req_rs  = rs3_q;
                end
                if ((remain & ~req_oh) == 3'b000) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wis_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
            need_q  <= 3'b000;
            sent_q  <= 3'b000;
            meta_q  <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            pend_q  <= 1'b0;
            pidx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= req_v;
            pidx_q  <= req_idx;
            if (accept) begin
                wis_q  <= in_wis;
                rs1_q  <= in_rs1;
                rs2_q  <= in_rs2;
                rs3_q  <= in_rs3;
                need_q <= in_need;
                sent_q <= 3'b000;
                meta_q <= in_meta;
            end
            if (req_v) begin
                sent_q <= sent_q | req_oh;
            end
            // Response lands one cycle after its request.
            if (pend_q) begin
                case (pidx_q)
                    2'd0:    d1_q <= gpr_rsp_data;
                    2'd1:    d2_q <= gpr_rsp_data;
                    default: d3_q <= gpr_rsp_data;
                endcase
            end
            if (state_q == OUT && out_ready) begin
                d1_q <= '0;
                d2_q <= '0;
                d3_q <= '0;
            end
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == OUT);
    assign gpr_req_valid = req_v;
    assign gpr_req_addr  = req_v ? {wis_q, req_rs} : '0;
    assign out_meta      = meta_q;
    assign out_rs1_data  = d1_q;
    assign out_rs2_data  = d2_q;
    assign out_rs3_data  = d3_q;

endmodule

// File: doc/vx_operand_gather.md
Name: vx_operand_gather

Overview:
- Operand-fetch stage between the scoreboard/issue output and the dispatch stage.
- Accepts one issued instruction at a time and reads its rs1/rs2/rs3 thread vectors from a single-read-port GPR bank, one register per cycle.
- Presents the assembled operand packet to dispatch over a valid/ready handshake.
- Instruction metadata (uuid, tmask, PC, op fields, imm, rd, ...) is carried opaquely as a packed word.

Parameters:
- NUM_THREADS, 4, threads per warp; width multiplier of operand vectors.
- XLEN, 32, register width in bits.
- NR_BITS, 6, register index width (0..63; index 0 is hardwired zero).
- WIS_BITS, 2, issue-slot warp index width.
- META_W, 128, width of the opaque metadata word.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  issued instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_meta  in  META_W  opaque instruction metadata.
- in_wis  in  WIS_BITS  warp issue slot.
- in_rs1 / in_rs2 / in_rs3  in  NR_BITS each  source register indices.
- in_rs_mask  in  3  bit i set means operand i+1 is used.
- gpr_req_valid  out  1  GPR read request (port always accepts).
- gpr_req_addr  out  WIS_BITS+NR_BITS  read address {wis, rs}.
- gpr_rsp_data  in  NUM_THREADS*XLEN  read data, valid exactly 1 cycle after the request.
- out_valid  out  1  operand packet valid.
- out_ready  in  1  dispatch accepts the packet.
- out_meta  out  META_W  registered copy of in_meta.
- out_rs1_data / out_rs2_data / out_rs3_data  out  NUM_THREADS*XLEN each  operand vectors.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - out_valid=0, gpr_req_valid=0.
  - All out_* data registers are 0.
  - Request index is 0.
- Reset mid-operation: aborts the instruction. No further GPR requests are issued. A response arriving in the reset cycle is discarded.
- Need mask: need[i] = in_rs_mask[i] && (rs_i != 0). It is latched at accept with wis, the rs indices and meta.
  - Operands with need[i]=0 are output as all-zero.
  - No read is issued for a register-0 source or an unused operand.
- in_ready = (state==IDLE). Accept happens when in_valid && in_ready. No accept occurs in any other state.
- States:
  - IDLE
    - On accept with N = popcount(need) > 0, go to REQ.
    - On accept with N == 0, go to OUT.
  - REQ
    - Each cycle, issue one read (gpr_req_valid=1) for the lowest-numbered needed operand not yet requested, in order rs1 -> rs2 -> rs3.
    - Capture gpr_rsp_data from the previous cycle's request into its operand slot.
    - After issuing the last needed read, go to DRAIN.
  - DRAIN
    - gpr_req_valid=0.
    - Capture the final response, then go to OUT.
  - OUT
    - out_valid=1. Outputs are held stable until out_ready.
    - On out_valid && out_ready, go to IDLE. Operand registers are cleared to 0 on this transition.
- Response tagging: a one-cycle delayed copy of the issued operand index selects the capture slot. The response is captured only when the delayed request-valid bit is set.
- Latency, with accept in cycle T:
  - N>0: first request at T+1, last request at T+N, out_valid at T+N+2.
  - N=0: out_valid at T+1.
- Throughput: one instruction per N+3 cycles (N>0) or 2 cycles (N=0) when out_ready stays high. This is the minimum: IDLE is always visited between packets.
- Backpressure: out_ready low holds OUT indefinitely. in_ready stays 0 and no GPR activity occurs.
- gpr_req_addr is don't-care when gpr_req_valid=0; drive it to 0.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
- Reset, then in_valid=1 with mask=3'b111, rs1=5, rs2=6, rs3=7, wis=1 -> in_ready=1 only in the accept cycle.
  - gpr_req_addr={1,5},{1,6},{1,7} on T+1..T+3.
  - out_valid at T+5 with each operand equal to the data returned for its register.
- mask=3'b011, rs1=0, rs2=9 -> exactly one request, addr {wis,9}, at T+1.
  - out_valid at T+3, out_rs1_data=0, out_rs3_data=0.
- mask=3'b000 -> no requests, out_valid at T+1, all operand data 0, out_meta=in_meta.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> outputs stable, in_ready=0, gpr_req_valid=0.
  - Raising out_ready completes the handshake; in_ready=1 the following cycle.
- Assert reset in the cycle of the second of three requests -> next cycle: state IDLE, out_valid=0, no third request.
  - A following instruction completes normally with no stale data.
- Back-to-back: 4 instructions, mask=3'b111, out_ready=1 -> successive out_valid pulses 6 cycles apart, metadata in order.
